// File: rtl/ps2_keymap_tracker.sv
// PS/2 set-2 key tracker: decodes E0/F0 prefixes, keeps a held-key bitmap for a
// configurable key table and queues deduplicated make/break events in a FWFT FIFO.
//
// state  | meaning
// IDLE   | no prefix pending
// EXT    | E0 received, waiting for code or F0
// BRK    | F0 received, next byte is a plain break code
// EXTBRK | E0 F0 received, next byte is an extended break code
module ps2_keymap_tracker #(
   parameter int                    NUM_KEYS   = 4,
   parameter logic [9*NUM_KEYS-1:0] KEY_TABLE  = {9'h174, 9'h172, 9'h16B, 9'h175},
   parameter int                    FIFO_DEPTH = 8,
   localparam int                   IDXW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
   localparam int                   PTRW       = $clog2(FIFO_DEPTH),
   localparam int                   CNTW       = PTRW + 1
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                ps2_key_pressed,
   input  logic [7:0]          ps2_key_data,
   input  logic                flush,
   input  logic                evt_ready,
   input  logic                ovf_clr,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                any_held,
   output logic                evt_valid,
   output logic [IDXW:0]       evt_data,
   output logic [CNTW-1:0]     evt_count,
   output logic                overflow,
   output logic [8:0]          last_code
);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

   state_t              state_q, state_d;
   logic [NUM_KEYS-1:0] key_held_q, key_held_d;
   logic [8:0]          last_code_q;
   logic                overflow_q;

   logic [IDXW:0]       mem_q [FIFO_DEPTH];
   logic [PTRW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0]     count_q;

   logic                stb;
   logic                cmpl, cmpl_brk, cmpl_ext;
   logic [8:0]          code;
   logic                hit;
   logic [IDXW-1:0]     hit_idx;
   logic                push, pop, full, wr_en, drop;

   // Flush discards any byte arriving in the same cycle.
   assign stb  = ps2_key_pressed & ~flush;
   assign code = {cmpl_ext, ps2_key_data};

   // Prefix decode: decide next state and whether this byte completes a code.
   always_comb begin
      state_d  = state_q;
      cmpl     = 1'b0;
      cmpl_brk = 1'b0;
      cmpl_ext = 1'b0;
      if (stb) begin
         unique case (state_q)
            S_IDLE: begin
               if (ps2_key_data == 8'hE0)      state_d = S_EXT;
               else if (ps2_key_data == 8'hF0) state_d = S_BRK;
               else if (!(ps2_key_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1}))
                  cmpl = 1'b1;
            end
            S_EXT: begin
               if (ps2_key_data == 8'hF0) state_d = S_EXTBRK;
               else begin
                  cmpl     = 1'b1;
                  cmpl_ext = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_BRK: begin
               cmpl     = 1'b1;
               cmpl_brk = 1'b1;
               state_d  = S_IDLE;
            end
            S_EXTBRK: begin
               cmpl     = 1'b1;
               cmpl_brk = 1'b1;
               cmpl_ext = 1'b1;
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Parallel table lookup; scanning downward lets the lowest matching index win.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (KEY_TABLE[9*i +: 9] == code) begin
            hit     = 1'b1;
            hit_idx = IDXW'(i);
         end
      end
   end

   // An event only fires on a real state change of the key (typematic repeats are dropped).
   always_comb begin
      key_held_d = key_held_q;
      push       = cmpl && hit && (cmpl_brk == key_held_q[hit_idx]);
      if (push) key_held_d[hit_idx] = ~cmpl_brk;
   end

   assign full  = (count_q == CNTW'(FIFO_DEPTH));
   assign pop   = (count_q != '0) && evt_ready && !flush;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   // Decoder FSM with held-key bitmap and last completed code.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         key_held_q  <= '0;
         last_code_q <= '0;
      end else if (flush) begin
         state_q     <= S_IDLE;
         key_held_q  <= '0;
      end else begin
         state_q    <= state_d;
         key_held_q <= key_held_d;
         if (cmpl) last_code_q <= code;
      end
   end

   // FIFO storage; contents are only observed through valid pointers, so no reset.
   always_ff @(posedge clock) begin
      if (wr_en && !flush) mem_q[wr_ptr_q] <= {cmpl_brk, hit_idx};
   end

   // FIFO pointers and occupancy; pointer width makes wrap implicit.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_en && !pop)      count_q <= count_q + 1'b1;
         else if (!wr_en && pop) count_q <= count_q - 1'b1;
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)      overflow_q <= 1'b0;
      else if (drop)    overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
   end

   assign key_held  = key_held_q;
   assign any_held  = |key_held_q;
   assign evt_valid = (count_q != '0);
   assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
   assign evt_count = count_q;
   assign overflow  = overflow_q;
   assign last_code = last_code_q;

endmodule

// File: tb/tb_ps2_keymap_tracker.sv
// Self-checking bench for ps2_keymap_tracker: directed scenarios plus random byte
// streams compared every cycle against a queue-based behavioural model.
module tb_ps2_keymap_tracker;
   localparam int NK = 4;
   localparam int FD = 8;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       stb = 1'b0, flush = 1'b0, rdy = 1'b0, oclr = 1'b0;
   logic [7:0] data = 8'h00;
   logic [3:0] key_held;
   logic       any_held, evt_valid, overflow;
   logic [2:0] evt_data;
   logic [3:0] evt_count;
   logic [8:0] last_code;

   logic       stb1 = 1'b0, rdy1 = 1'b0;
   logic [7:0] data1 = 8'h00;
   logic [0:0] held1;
   logic       any1, valid1, ovf1;
   logic [1:0] edata1;
   logic [3:0] count1;
   logic [8:0] last1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   ps2_keymap_tracker u_dut (
      .clock(clock), .resetn(resetn), .ps2_key_pressed(stb), .ps2_key_data(data),
      .flush(flush), .evt_ready(rdy), .ovf_clr(oclr), .key_held(key_held),
      .any_held(any_held), .evt_valid(evt_valid), .evt_data(evt_data),
      .evt_count(evt_count), .overflow(overflow), .last_code(last_code)
   );

   ps2_keymap_tracker #(.NUM_KEYS(1), .KEY_TABLE(9'h029), .FIFO_DEPTH(8)) u_dut1 (
      .clock(clock), .resetn(resetn), .ps2_key_pressed(stb1), .ps2_key_data(data1),
      .flush(1'b0), .evt_ready(rdy1), .ovf_clr(1'b0), .key_held(held1),
      .any_held(any1), .evt_valid(valid1), .evt_data(edata1),
      .evt_count(count1), .overflow(ovf1), .last_code(last1)
   );

   // Reference model: prefix flags, held bitmap, event queue of {break,idx}
   bit         m_ext, m_brk, m_ovf;
   bit [3:0]   m_held;
   bit [8:0]   m_last;
   int         m_q[$];
   bit [8:0]   tbl[NK] = '{9'h175, 9'h16B, 9'h172, 9'h174};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_held = '0; m_last = '0;
      m_q.delete();
   endtask

   task automatic model_step(input bit s, input bit [7:0] d, input bit r, input bit f, input bit oc);
      bit pop, cmpl, cb, ce;
      int sz, idx;
      if (oc) m_ovf = 0;
      if (f) begin
         m_q.delete(); m_held = '0; m_ext = 0; m_brk = 0;
         return;
      end
      pop = (m_q.size() > 0) && r;
      cmpl = 0; cb = 0; ce = 0;
      if (s) begin
         if (!m_ext && !m_brk) begin
            if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else if (!(d inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1})) cmpl = 1;
         end else if (!m_brk) begin
            if (d == 8'hF0) m_brk = 1;
            else begin cmpl = 1; ce = 1; m_ext = 0; end
         end else begin
            cmpl = 1; cb = 1; ce = m_ext; m_ext = 0; m_brk = 0;
         end
      end
      sz = m_q.size();
      if (pop) void'(m_q.pop_front());
      if (cmpl) begin
         m_last = {ce, d};
         idx = -1;
         for (int i = NK - 1; i >= 0; i--) if (tbl[i] == {ce, d}) idx = i;
         if (idx >= 0 && (cb ? m_held[idx] : !m_held[idx])) begin
            m_held[idx] = !cb;
            if (sz < FD || pop) m_q.push_back(int'(cb) * 4 + idx);
            else m_ovf = 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int exp_head;
      exp_head = (m_q.size() > 0) ? m_q[0] : 0;
      chk({tag, ".held"},  32'(key_held),  32'(m_held));
      chk({tag, ".any"},   32'(any_held),  32'(|m_held));
      chk({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
      chk({tag, ".data"},  32'(evt_data),  32'(exp_head));
      chk({tag, ".count"}, 32'(evt_count), 32'(m_q.size()));
      chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
      chk({tag, ".last"},  32'(last_code), 32'(m_last));
   endtask

   task automatic cycle(input string tag, input bit s, input bit [7:0] d,
                        input bit r = 0, input bit f = 0, input bit oc = 0);
      stb = s; data = d; rdy = r; flush = f; oclr = oc;
      @(posedge clock);
      model_step(s, d, r, f, oc);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      stb = 0; rdy = 0; flush = 0; oclr = 0; data = 8'h00;
      #2 resetn = 1'b0;
      model_reset();
      #1 check_all("reset");
      #3 resetn = 1'b1;
   endtask

   task automatic cyc1(input bit s, input bit [7:0] d, input bit r);
      stb1 = s; data1 = d; rdy1 = r;
      @(posedge clock);
      #1;
   endtask

   function automatic bit [7:0] rand_byte();
      int r;
      bit [7:0] codes[4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
      bit [7:0] ign[5]   = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1};
      r = $urandom_range(0, 99);
      if (r < 22) return 8'hE0;
      if (r < 40) return 8'hF0;
      if (r < 80) return codes[$urandom_range(0, 3)];
      if (r < 88) return ign[$urandom_range(0, 4)];
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      model_reset();
      #7;
      check_all("reset0");
      chk("reset0.dut1_count", 32'(count1), 32'd0);
      resetn = 1'b1;

      // 1: plain 75 does not match; E0 75 makes key 0
      cycle("t1_75", 1, 8'h75);
      chk("t1_nomatch", 32'(evt_valid), 32'd0);
      cycle("t1_e0", 1, 8'hE0);
      cycle("t1_e075", 1, 8'h75);
      chk("t1_held", 32'(key_held), 32'h1);
      chk("t1_evt", 32'(evt_data), 32'h0);

      // 2: typematic repeats then extended break
      cycle("t2_flush", 0, 8'h00, 0, 1);
      for (int k = 0; k < 3; k++) begin
         cycle("t2_e0", 1, 8'hE0);
         cycle("t2_75", 1, 8'h75);
      end
      cycle("t2_e0", 1, 8'hE0);
      cycle("t2_f0", 1, 8'hF0);
      cycle("t2_75b", 1, 8'h75);
      chk("t2_count", 32'(evt_count), 32'd2);
      chk("t2_held", 32'(key_held), 32'h0);
      cycle("t2_pop", 0, 8'h00, 1);
      chk("t2_head2", 32'(evt_data), 32'h4);
      cycle("t2_pop2", 0, 8'h00, 1);

      // 3: nine events into a depth-8 FIFO with no consumer
      cycle("t3_flush", 0, 8'h00, 0, 1);
      for (int k = 0; k < 9; k++) begin
         bit [7:0] cds[4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
         cycle("t3_e0", 1, 8'hE0);
         if (k >= 4 && k < 8) cycle("t3_f0", 1, 8'hF0);
         cycle("t3_code", 1, cds[k % 4]);
      end
      chk("t3_count", 32'(evt_count), 32'd8);
      chk("t3_ovf", 32'(overflow), 32'd1);
      cycle("t3_clr", 0, 8'h00, 0, 0, 1);
      chk("t3_ovf_clr", 32'(overflow), 32'd0);

      // 4: push and pop together while full
      cycle("t4_e0", 1, 8'hE0);
      cycle("t4_f0", 1, 8'hF0);
      cycle("t4_75", 1, 8'h75, 1);
      chk("t4_count", 32'(evt_count), 32'd8);
      chk("t4_ovf", 32'(overflow), 32'd0);
      chk("t4_head", 32'(evt_data), 32'h1);
      for (int k = 0; k < 8; k++) cycle("t4_drain", 0, 8'h00, 1);
      chk("t4_empty", 32'(evt_valid), 32'd0);

      // 5: reset and flush discard pending prefixes
      cycle("t5_e0", 1, 8'hE0);
      do_reset();
      cycle("t5_75", 1, 8'h75);
      chk("t5_noevt_rst", 32'(evt_count), 32'd0);
      cycle("t5_f0", 1, 8'hF0);
      cycle("t5_flush", 0, 8'h00, 0, 1);
      cycle("t5_6b", 1, 8'h6B);
      chk("t5_noevt_flush", 32'(evt_count), 32'd0);

      // random stream against the model
      for (int k = 0; k < 3000; k++) begin
         bit s, r, f, oc;
         s  = ($urandom_range(0, 99) < 75);
         r  = ($urandom_range(0, 99) < 30);
         f  = ($urandom_range(0, 99) < 2);
         oc = ($urandom_range(0, 99) < 4);
         cycle("rand", s, rand_byte(), r, f, oc);
      end

      // 6: single-key instance (space bar)
      cycle("t6_idle", 0, 8'h00);
      cyc1(1, 8'hAA, 0);
      cyc1(1, 8'hFA, 0);
      chk("t6_ign_last", 32'(last1), 32'h0);
      chk("t6_ign_count", 32'(count1), 32'd0);
      cyc1(1, 8'h29, 0);
      chk("t6_make_held", 32'(held1), 32'd1);
      chk("t6_make_valid", 32'(valid1), 32'd1);
      chk("t6_make_evt", 32'(edata1), 32'h0);
      chk("t6_make_last", 32'(last1), 32'h029);
      cyc1(1, 8'hF0, 0);
      cyc1(1, 8'h29, 0);
      chk("t6_brk_held", 32'(held1), 32'd0);
      chk("t6_brk_count", 32'(count1), 32'd2);
      cyc1(0, 8'h00, 1);
      chk("t6_pop_count", 32'(count1), 32'd1);
      chk("t6_pop_evt", 32'(edata1), 32'h2);
      cyc1(0, 8'h00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
